// File: rtl/hardisc_ahb_arbiter.sv
// N-master to 1-slave AHB-Lite arbiter with per-master hready/hresp tracking
// and pass-through of the address/control parity and data checksums.
module hardisc_ahb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 1,
    parameter int PARK_MASTER = 0,
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                     s_clk_i,
    input  logic                     s_resetn_i,
    input  logic [NUM_MASTERS*32-1:0] s_m_haddr_i,
    input  logic [NUM_MASTERS*2-1:0]  s_m_htrans_i,
    input  logic [NUM_MASTERS-1:0]    s_m_hwrite_i,
    input  logic [NUM_MASTERS*3-1:0]  s_m_hsize_i,
    input  logic [NUM_MASTERS*32-1:0] s_m_hwdata_i,
    input  logic [NUM_MASTERS*7-1:0]  s_m_hwchecksum_i,
    input  logic [NUM_MASTERS*6-1:0]  s_m_hparity_i,
    output logic [NUM_MASTERS-1:0]    s_m_hready_o,
    output logic [NUM_MASTERS-1:0]    s_m_hresp_o,
    output logic [31:0]               s_m_hrdata_o,
    output logic [6:0]                s_m_hrchecksum_o,
    output logic [31:0]               s_haddr_o,
    output logic [1:0]                s_htrans_o,
    output logic                      s_hwrite_o,
    output logic [2:0]                s_hsize_o,
    output logic [31:0]               s_hwdata_o,
    output logic [6:0]                s_hwchecksum_o,
    output logic [5:0]                s_hparity_o,
    input  logic [31:0]               s_hrdata_i,
    input  logic [6:0]                s_hrchecksum_i,
    input  logic                      s_hready_i,
    input  logic                      s_hresp_i,
    output logic [IW-1:0]             s_owner_o,
    output logic                      s_owner_valid_o
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [NUM_MASTERS-1:0] req;
    logic [IW-1:0]          grant_q, grant_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic                   owner_valid_q, owner_valid_d;
    logic [IW-1:0]          last_q, last_d;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) req[i] = s_m_htrans_i[2*i+1];
    end

    // Grant selection; an unaccepted grant is frozen while the slave stalls.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        grant_d       = IW'(PARK_MASTER);
        grant_valid_d = 1'b0;
        found         = 1'b0;
        cand          = '0;
        if (!s_hready_i && grant_valid_q) begin
            grant_d       = grant_q;
            grant_valid_d = 1'b1;
        end else if (ARB_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_d       = IW'(i);
                    grant_valid_d = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = IW'((int'(last_q) + k) % NUM_MASTERS);
                if (!found && req[cand]) begin
                    grant_d = cand;
                    found   = 1'b1;
                end
            end
            grant_valid_d = found;
        end
    end

    always_comb begin
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        last_d        = last_q;
        if (s_hready_i) begin
            owner_d       = grant_d;
            owner_valid_d = grant_valid_d;
            if (grant_valid_d) last_d = grant_d;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            last_q        <= IW'(NUM_MASTERS - 1);
        end else begin
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            last_q        <= last_d;
        end
    end

    // With no grant grant_d already points at the park master.
    always_comb begin
        s_haddr_o   = s_m_haddr_i[32*int'(grant_d) +: 32];
        s_hwrite_o  = s_m_hwrite_i[grant_d];
        s_hsize_o   = s_m_hsize_i[3*int'(grant_d) +: 3];
        s_hparity_o = s_m_hparity_i[6*int'(grant_d) +: 6];
        s_htrans_o  = grant_valid_d ? s_m_htrans_i[2*int'(grant_d) +: 2] : HTRANS_IDLE;
    end

    always_comb begin
        s_hwdata_o     = '0;
        s_hwchecksum_o = '0;
        if (owner_valid_q) begin
            s_hwdata_o     = s_m_hwdata_i[32*int'(owner_q) +: 32];
            s_hwchecksum_o = s_m_hwchecksum_i[7*int'(owner_q) +: 7];
        end
    end

    always_comb begin
        logic own, owner_term, addr_term;
        own        = 1'b0;
        owner_term = 1'b1;
        addr_term  = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            own             = owner_valid_q && (owner_q == IW'(i));
            owner_term      = own ? s_hready_i : 1'b1;
            addr_term       = !req[i] || (grant_valid_d && (grant_d == IW'(i)) && s_hready_i);
            s_m_hready_o[i] = owner_term && addr_term;
            s_m_hresp_o[i]  = own && s_hresp_i;
        end
    end

    assign s_m_hrdata_o     = s_hrdata_i;
    assign s_m_hrchecksum_o = s_hrchecksum_i;
    assign s_owner_o        = owner_q;
    assign s_owner_valid_o  = owner_valid_q;

endmodule

// File: tb/tb_hardisc_ahb_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters driven by the same
// two masters, checked against hand-computed values.
module tb_hardisc_ahb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] m_haddr, m_hwdata;
    logic [3:0]  m_htrans;
    logic [1:0]  m_hwrite;
    logic [5:0]  m_hsize;
    logic [13:0] m_hwchk;
    logic [11:0] m_hpar;
    logic [31:0] hrdata;
    logic [6:0]  hrchk;
    logic        hready, hresp;

    logic [1:0]  r_hready, r_hresp, f_hready, f_hresp;
    logic [31:0] r_hrdata, r_haddr, r_hwdata, f_hrdata, f_haddr, f_hwdata;
    logic [6:0]  r_hrchk, r_hwchk, f_hrchk, f_hwchk;
    logic [1:0]  r_htrans, f_htrans;
    logic        r_hwrite, f_hwrite, r_owner, f_owner, r_ov, f_ov;
    logic [2:0]  r_hsize, f_hsize;
    logic [5:0]  r_hpar, f_hpar;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hardisc_ahb_arbiter #(.NUM_MASTERS(2), .ARB_MODE(1), .PARK_MASTER(0)) dut_rr (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_m_haddr_i(m_haddr), .s_m_htrans_i(m_htrans), .s_m_hwrite_i(m_hwrite),
        .s_m_hsize_i(m_hsize), .s_m_hwdata_i(m_hwdata), .s_m_hwchecksum_i(m_hwchk),
        .s_m_hparity_i(m_hpar), .s_m_hready_o(r_hready), .s_m_hresp_o(r_hresp),
        .s_m_hrdata_o(r_hrdata), .s_m_hrchecksum_o(r_hrchk),
        .s_haddr_o(r_haddr), .s_htrans_o(r_htrans), .s_hwrite_o(r_hwrite),
        .s_hsize_o(r_hsize), .s_hwdata_o(r_hwdata), .s_hwchecksum_o(r_hwchk),
        .s_hparity_o(r_hpar), .s_hrdata_i(hrdata), .s_hrchecksum_i(hrchk),
        .s_hready_i(hready), .s_hresp_i(hresp),
        .s_owner_o(r_owner), .s_owner_valid_o(r_ov)
    );

    hardisc_ahb_arbiter #(.NUM_MASTERS(2), .ARB_MODE(0), .PARK_MASTER(0)) dut_fp (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_m_haddr_i(m_haddr), .s_m_htrans_i(m_htrans), .s_m_hwrite_i(m_hwrite),
        .s_m_hsize_i(m_hsize), .s_m_hwdata_i(m_hwdata), .s_m_hwchecksum_i(m_hwchk),
        .s_m_hparity_i(m_hpar), .s_m_hready_o(f_hready), .s_m_hresp_o(f_hresp),
        .s_m_hrdata_o(f_hrdata), .s_m_hrchecksum_o(f_hrchk),
        .s_haddr_o(f_haddr), .s_htrans_o(f_htrans), .s_hwrite_o(f_hwrite),
        .s_hsize_o(f_hsize), .s_hwdata_o(f_hwdata), .s_hwchecksum_o(f_hwchk),
        .s_hparity_o(f_hpar), .s_hrdata_i(hrdata), .s_hrchecksum_i(hrchk),
        .s_hready_i(hready), .s_hresp_i(hresp),
        .s_owner_o(f_owner), .s_owner_valid_o(f_ov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mset(input int i, input logic [1:0] tr, input logic [31:0] a, input logic w);
        m_htrans[2*i +: 2] = tr;
        m_haddr[32*i +: 32] = a;
        m_hwrite[i]         = w;
    endtask

    initial begin
        rst_n    = 1'b0;
        m_haddr  = '0; m_hwdata = '0; m_htrans = '0; m_hwrite = '0;
        m_hsize  = 6'b010_010; m_hwchk = '0; m_hpar = '0;
        hrdata   = '0; hrchk = '0; hready = 1'b1; hresp = 1'b0;
        mset(0, 2'b00, 32'h1000, 1'b0);
        mset(1, 2'b00, 32'h2000, 1'b0);
        #2;
        chk("rst_htrans", r_htrans, 0);
        chk("rst_haddr_park", r_haddr, 32'h1000);
        chk("rst_hready", r_hready, 2'b11);
        chk("rst_hresp", r_hresp, 0);
        chk("rst_owner_valid", r_ov, 0);
        chk("rst_owner", r_owner, 0);

        // Single write by M0
        nxt();
        rst_n = 1'b1;
        mset(0, 2'b10, 32'h1000, 1'b1);
        m_hwdata[31:0] = 32'hDEADBEEF;
        m_hwchk[6:0]   = 7'h55;
        m_hpar[5:0]    = 6'h2A;
        #2;
        chk("wr_addr", r_haddr, 32'h1000);
        chk("wr_htrans", r_htrans, 2);
        chk("wr_hwrite", r_hwrite, 1);
        chk("wr_parity", r_hpar, 6'h2A);
        chk("wr_addr_hready", r_hready, 2'b11);
        chk("wr_addr_hwdata_zero", r_hwdata, 0);
        nxt();
        mset(0, 2'b00, 32'h1000, 1'b0);
        hrdata = 32'h12345678; hrchk = 7'h11;
        #2;
        chk("wr_data_hwdata", r_hwdata, 32'hDEADBEEF);
        chk("wr_data_hwchk", r_hwchk, 7'h55);
        chk("wr_data_owner", r_owner, 0);
        chk("wr_data_owner_valid", r_ov, 1);
        chk("idle_htrans", r_htrans, 0);
        chk("rdata_pass", r_hrdata, 32'h12345678);
        chk("rchk_pass", r_hrchk, 7'h11);
        nxt();
        #2;
        chk("idle_owner_valid", r_ov, 0);
        chk("idle_hwdata", r_hwdata, 0);

        // Both masters request continuously
        nxt();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        mset(0, 2'b10, 32'h100, 1'b0);
        mset(1, 2'b10, 32'h200, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_haddr", r_haddr, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("rr_hready", r_hready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("fp_haddr", f_haddr, 32'h100);
            chk("fp_hready", f_hready, 2'b01);
            if (k > 0) chk("rr_owner", r_owner, (k % 2 == 0) ? 1 : 0);
            nxt();
            #2;
        end

        // M1 owns the data phase, slave inserts three wait states
        mset(0, 2'b10, 32'h300, 1'b0);
        mset(1, 2'b00, 32'h200, 1'b0);
        m_hwdata[63:32] = 32'hCAFEF00D;
        hready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ws_haddr_stable", r_haddr, 32'h200);
            chk("ws_htrans", r_htrans, 0);
            chk("ws_hready", r_hready, 2'b00);
            chk("ws_owner", r_owner, 1);
            chk("ws_hwdata", r_hwdata, 32'hCAFEF00D);
            nxt();
            #2;
        end
        hready = 1'b1;
        #1;
        chk("ws_accept_haddr", r_haddr, 32'h300);
        chk("ws_accept_htrans", r_htrans, 2);
        chk("ws_accept_hready", r_hready, 2'b11);

        // Two-cycle error on M1 read while M0 waits
        nxt();
        mset(0, 2'b00, 32'h300, 1'b0);
        mset(1, 2'b10, 32'h400, 1'b0);
        #2;
        chk("err_rd_addr", r_haddr, 32'h400);
        chk("err_rd_hwrite", r_hwrite, 0);
        nxt();
        mset(0, 2'b10, 32'h500, 1'b0);
        mset(1, 2'b00, 32'h400, 1'b0);
        hresp = 1'b1; hready = 1'b0;
        #2;
        chk("err1_hresp", r_hresp, 2'b10);
        chk("err1_hready", r_hready, 2'b00);
        nxt();
        hready = 1'b1;
        #2;
        chk("err2_hresp", r_hresp, 2'b10);
        chk("err2_haddr_m0", r_haddr, 32'h500);
        chk("err2_htrans", r_htrans, 2);
        chk("err2_hready", r_hready, 2'b11);
        nxt();
        mset(0, 2'b00, 32'h500, 1'b0);
        hresp = 1'b0;
        #2;
        chk("post_err_owner", r_owner, 0);
        chk("post_err_owner_valid", r_ov, 1);
        chk("post_err_hresp", r_hresp, 0);

        // Reset asserted in the middle of a wait state
        hready = 1'b0;
        mset(0, 2'b10, 32'h700, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_owner_valid", r_ov, 0);
        chk("midrst_fp_owner_valid", f_ov, 0);
        mset(0, 2'b00, 32'h700, 1'b0);
        hready = 1'b1;
        #1;
        chk("midrst_hready", r_hready, 2'b11);
        chk("midrst_htrans", r_htrans, 0);
        nxt();
        rst_n = 1'b1;

        // Back-to-back burst by M0 on the fixed-priority arbiter
        for (int k = 0; k < 3; k++) begin
            mset(0, (k == 0) ? 2'b10 : 2'b11, 32'h600 + 32'(4*k), 1'b0);
            #2;
            chk("b2b_haddr", f_haddr, 32'h600 + 32'(4*k));
            chk("b2b_htrans", f_htrans, (k == 0) ? 2 : 3);
            chk("b2b_hready", f_hready, 2'b11);
            chk("b2b_owner_valid", f_ov, (k == 0) ? 0 : 1);
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
